// File: rtl/xifo_pkg.sv
// rtl/xifo_pkg.sv - shared constants and helpers for the xifo stack/queue buffer
package xifo_pkg;

  localparam int MODE_STACK = 0;
  localparam int MODE_QUEUE = 1;

  localparam int SIZE_MIN       = 8;
  localparam int SIZE_MAX       = 32;
  localparam int ADDR_WIDTH_MIN = 2;
  localparam int ADDR_WIDTH_MAX = 10;

  function automatic int xifo_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xifo_ram.sv
// rtl/xifo_ram.sv - simple dual-port RAM, one write port, one read port with registered output
module xifo_ram #(
  parameter int SIZE       = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE-1:0]       wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [SIZE-1:0]       rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [SIZE-1:0] rd_data_d;
  logic [SIZE-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Same-edge read and write of one address returns the old word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/xifo_buffer.sv
// rtl/xifo_buffer.sv - single-clock stack/queue buffer; XIFO_ALMOST_EN adds almost-full/empty flags
module xifo_buffer
  import xifo_pkg::*;
#(
  parameter int MODE       = MODE_STACK,
  parameter int SIZE       = 16,
  parameter int ADDR_WIDTH = 3
`ifdef XIFO_ALMOST_EN
  ,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
`endif
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Wren,
  input  logic                  Rden,
  input  logic [SIZE-1:0]       Datain,
  output logic [SIZE-1:0]       Dataout,
  output logic                  Rvalid,
  output logic                  Full,
  output logic                  Empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
`ifdef XIFO_ALMOST_EN
  ,
  output logic                  Almost_full,
  output logic                  Almost_empty
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = xifo_clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0]         count_d, count_q;
  logic                  full_d, full_q;
  logic                  empty_d, empty_q;
  logic                  rvalid_d, rvalid_q;
  logic                  overflow_d, overflow_q;
  logic                  underflow_d, underflow_q;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] sp_top;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;

  always_comb begin
    // A full buffer still takes a write when a read frees a slot on the same edge.
    wr_acc      = Wren && (!full_q || Rden);
    rd_acc      = Rden && !empty_q;
    overflow_d  = Wren && !wr_acc;
    underflow_d = Rden && !rd_acc;
    rvalid_d    = rd_acc;

    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sp_top      = ADDR_WIDTH'(count_q - 1'b1);
    mem_wr_addr = wr_ptr_q;
    mem_rd_addr = rd_ptr_q;

    if (MODE == MODE_QUEUE) begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      // Stack pointer is the occupancy; a pop+push overwrites the current top.
      mem_rd_addr = sp_top;
      mem_wr_addr = rd_acc ? sp_top : ADDR_WIDTH'(count_q);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  xifo_ram #(
    .SIZE       (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (Clk),
    .rst     (Rst),
    .wr_en   (wr_acc),
    .wr_addr (mem_wr_addr),
    .wr_data (Datain),
    .rd_en   (rd_acc),
    .rd_addr (mem_rd_addr),
    .rd_data (Dataout)
  );

  assign Rvalid    = rvalid_q;
  assign Full      = full_q;
  assign Empty     = empty_q;
  assign Count     = count_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;

`ifdef XIFO_ALMOST_EN
  localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);

  logic almost_full_d, almost_full_q;
  logic almost_empty_d, almost_empty_q;

  always_comb begin
    almost_full_d  = (count_d >= AF_CNT);
    almost_empty_d = (count_d <= AE_CNT);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign Almost_full  = almost_full_q;
  assign Almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_xifo_buffer.sv
// tb/tb_xifo_buffer.sv - scoreboard bench: one stack and one queue instance against a queue-based model
module tb_xifo_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_wren, s_rden, s_rvalid, s_full, s_empty, s_ovf, s_unf;
  logic [15:0] s_din, s_dout;
  logic [3:0]  s_count;
  logic        q_wren, q_rden, q_rvalid, q_full, q_empty, q_ovf, q_unf;
  logic [15:0] q_din, q_dout;
  logic [3:0]  q_count;
`ifdef XIFO_ALMOST_EN
  logic        s_af, s_ae, q_af, q_ae;
`endif

  xifo_buffer #(
    .MODE(0), .SIZE(16), .ADDR_WIDTH(3)
`ifdef XIFO_ALMOST_EN
    , .AF_LEVEL(6), .AE_LEVEL(1)
`endif
  ) u_stack (
    .Clk(clk), .Rst(rst), .Wren(s_wren), .Rden(s_rden), .Datain(s_din),
    .Dataout(s_dout), .Rvalid(s_rvalid), .Full(s_full), .Empty(s_empty),
    .Count(s_count), .Overflow(s_ovf), .Underflow(s_unf)
`ifdef XIFO_ALMOST_EN
    , .Almost_full(s_af), .Almost_empty(s_ae)
`endif
  );

  xifo_buffer #(
    .MODE(1), .SIZE(16), .ADDR_WIDTH(3)
`ifdef XIFO_ALMOST_EN
    , .AF_LEVEL(6), .AE_LEVEL(1)
`endif
  ) u_queue (
    .Clk(clk), .Rst(rst), .Wren(q_wren), .Rden(q_rden), .Datain(q_din),
    .Dataout(q_dout), .Rvalid(q_rvalid), .Full(q_full), .Empty(q_empty),
    .Count(q_count), .Overflow(q_ovf), .Underflow(q_unf)
`ifdef XIFO_ALMOST_EN
    , .Almost_full(q_af), .Almost_empty(q_ae)
`endif
  );

  typedef struct {
    logic [3:0]  cnt;
    logic        full, empty, ovf, unf, rv;
    logic [15:0] dout;
  } st_t;

  st_t         st_s[$], st_q[$];
  logic [15:0] rd_s[$], rd_q[$];
  logic [15:0] mdl_s[$], mdl_q[$];
  logic [15:0] last_s, last_q;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a list of 8 slots; queue takes the oldest, stack the newest.
  task automatic model(input bit is_q, input logic w, input logic r, input logic [15:0] d);
    st_t         e;
    int          n;
    logic        wa, ra;
    logic [15:0] v;
    n  = is_q ? mdl_q.size() : mdl_s.size();
    ra = r && (n > 0);
    wa = w && ((n < 8) || r);
    if (ra) begin
      if (is_q) begin v = mdl_q.pop_front(); rd_q.push_back(v); last_q = v; end
      else      begin v = mdl_s.pop_back();  rd_s.push_back(v); last_s = v; end
    end
    if (wa) begin
      if (is_q) mdl_q.push_back(d);
      else      mdl_s.push_back(d);
    end
    n       = is_q ? mdl_q.size() : mdl_s.size();
    e.cnt   = 4'(n);
    e.full  = (n == 8);
    e.empty = (n == 0);
    e.ovf   = w && !wa;
    e.unf   = r && !ra;
    e.rv    = ra;
    e.dout  = is_q ? last_q : last_s;
    if (is_q) st_q.push_back(e);
    else      st_s.push_back(e);
  endtask

  task automatic step(input logic ws, input logic rs, input logic [15:0] ds,
                      input logic wq, input logic rq, input logic [15:0] dq);
    @(negedge clk);
    s_wren = ws; s_rden = rs; s_din = ds;
    q_wren = wq; q_rden = rq; q_din = dq;
    model(1'b0, ws, rs, ds);
    model(1'b1, wq, rq, dq);
  endtask

  task automatic sstep(input logic w, input logic r, input logic [15:0] d);
    step(w, r, d, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic qstep(input logic w, input logic r, input logic [15:0] d);
    step(1'b0, 1'b0, 16'h0, w, r, d);
  endtask

  task automatic check_status(input string tag, input st_t e, input logic [3:0] cnt,
                              input logic full, input logic empty, input logic ovf,
                              input logic unf, input logic rv, input logic [15:0] dout);
    chk({tag, " count"},     cnt,   e.cnt);
    chk({tag, " full"},      full,  e.full);
    chk({tag, " empty"},     empty, e.empty);
    chk({tag, " overflow"},  ovf,   e.ovf);
    chk({tag, " underflow"}, unf,   e.unf);
    chk({tag, " rvalid"},    rv,    e.rv);
    chk({tag, " dataout"},   dout,  e.dout);
  endtask

  task automatic check_idle_reset(input string tag, input logic [3:0] cnt, input logic full,
                                  input logic empty, input logic rv, input logic ovf,
                                  input logic unf, input logic [15:0] dout);
    chk({tag, " reset count"},   cnt,   0);
    chk({tag, " reset full"},    full,  0);
    chk({tag, " reset empty"},   empty, 1);
    chk({tag, " reset rvalid"},  rv,    0);
    chk({tag, " reset ovf"},     ovf,   0);
    chk({tag, " reset unf"},     unf,   0);
    chk({tag, " reset dataout"}, dout,  0);
  endtask

  always @(posedge clk) begin : mon_stack
    st_t e;
    #1;
    if (st_s.size() > 0) begin
      e = st_s.pop_front();
      check_status("stack", e, s_count, s_full, s_empty, s_ovf, s_unf, s_rvalid, s_dout);
`ifdef XIFO_ALMOST_EN
      chk("stack almost_full",  s_af, e.cnt >= 6);
      chk("stack almost_empty", s_ae, e.cnt <= 1);
`endif
      if (s_rvalid) begin
        if (rd_s.size() == 0) chk("stack rvalid without pending read", s_rvalid, 0);
        else                  chk("stack read data", s_dout, rd_s.pop_front());
      end
    end
  end

  always @(posedge clk) begin : mon_queue
    st_t e;
    #1;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      check_status("queue", e, q_count, q_full, q_empty, q_ovf, q_unf, q_rvalid, q_dout);
`ifdef XIFO_ALMOST_EN
      chk("queue almost_full",  q_af, e.cnt >= 6);
      chk("queue almost_empty", q_ae, e.cnt <= 1);
`endif
      if (q_rvalid) begin
        if (rd_q.size() == 0) chk("queue rvalid without pending read", q_rvalid, 0);
        else                  chk("queue read data", q_dout, rd_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    s_wren = 0; s_rden = 0; s_din = 0;
    q_wren = 0; q_rden = 0; q_din = 0;
    last_s = 0; last_q = 0;
    repeat (2) @(negedge clk);
    check_idle_reset("stack", s_count, s_full, s_empty, s_rvalid, s_ovf, s_unf, s_dout);
    check_idle_reset("queue", q_count, q_full, q_empty, q_rvalid, q_ovf, q_unf, q_dout);
`ifdef XIFO_ALMOST_EN
    chk("reset almost_full",  q_af, 0);
    chk("reset almost_empty", q_ae, 1);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Queue fill, overflow, in-order drain
    for (int i = 1; i <= 8; i++) qstep(1, 0, 16'(i));
    qstep(1, 0, 16'h0009);
    repeat (8) qstep(0, 1, 16'h0);

    // Stack push/pop order and underflow hold
    sstep(1, 0, 16'h00A1);
    sstep(1, 0, 16'h00A2);
    sstep(1, 0, 16'h00A3);
    repeat (4) sstep(0, 1, 16'h0);

    // Queue pointer wrap
    for (int i = 0; i < 5; i++) qstep(1, 0, 16'h0010 + 16'(i));
    repeat (5) qstep(0, 1, 16'h0);
    for (int i = 0; i < 8; i++) qstep(1, 0, 16'h0020 + 16'(i));
    repeat (8) qstep(0, 1, 16'h0);

    // Queue simultaneous access: full, then empty
    for (int i = 0; i < 8; i++) qstep(1, 0, 16'h0030 + 16'(i));
    qstep(1, 1, 16'h0077);
    repeat (8) qstep(0, 1, 16'h0);
    qstep(1, 1, 16'h0033);
    qstep(0, 1, 16'h0);

    // Stack simultaneous access: top replace, full replace, overflow
    sstep(1, 0, 16'h0055);
    sstep(1, 1, 16'h0066);
    sstep(0, 1, 16'h0);
    sstep(1, 1, 16'h0044);
    sstep(0, 1, 16'h0);
    for (int i = 0; i < 8; i++) sstep(1, 0, 16'h0040 + 16'(i));
    sstep(1, 0, 16'h00EE);
    sstep(1, 1, 16'h0099);
    repeat (8) sstep(0, 1, 16'h0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0050 + 16'(i), 1, 0, 16'h0060 + 16'(i));
    sstep(0, 1, 16'h0);
    @(negedge clk);
    s_wren = 0; s_rden = 0; q_wren = 0; q_rden = 0;
    #2 rst = 1'b1;
    #1;
    check_idle_reset("stack mid", s_count, s_full, s_empty, s_rvalid, s_ovf, s_unf, s_dout);
    check_idle_reset("queue mid", q_count, q_full, q_empty, q_rvalid, q_ovf, q_unf, q_dout);
    mdl_s.delete(); mdl_q.delete();
    last_s = 0; last_q = 0;
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 16'h0, 0, 1, 16'h0);

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    end

    repeat (2) step(0, 0, 16'h0, 0, 0, 16'h0);
    repeat (3) @(negedge clk);
    chk("scoreboard drain", st_s.size() + st_q.size() + rd_s.size() + rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xifo_buffer.md
Name: xifo_buffer

Overview:
Single-clock, fully parametrised stack/queue buffer, the successor to the dual-mode Fifo/Lifo block. Compile-time mode selection, parametrised word width and depth, registered read data with a valid strobe, occupancy count and overflow/underflow pulses. Buffers 8–32-bit data between a producer and a consumer in the same clock domain. Defined behaviour for every simultaneous-access corner.

Parameters:
MODE, 0, 0 = stack (LIFO), 1 = queue (FIFO)
SIZE, 16, word width in bits; legal range 8–32
ADDR_WIDTH, 3, address bits; legal range 2–10
DEPTH, 1<<ADDR_WIDTH, derived localparam, not overridable
AF_LEVEL, DEPTH-1, almost-full threshold (optional feature only)
AE_LEVEL, 1, almost-empty threshold (optional feature only)

Ports:
Clk  in  1  single clock, rising edge
Rst  in  1  asynchronous reset, active-high
Wren  in  1  push/write request
Rden  in  1  pop/read request
Datain  in  SIZE  write data
Dataout  out  SIZE  registered read data
Rvalid  out  1  Dataout updated this cycle
Full  out  1  Count == DEPTH
Empty  out  1  Count == 0
Count  out  ADDR_WIDTH+1  current occupancy
Overflow  out  1  one-cycle pulse: write rejected
Underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (asynchronous, active-high): wr/rd pointers, stack pointer, Count, Dataout, Rvalid, Overflow and Underflow go to 0. Empty = 1, Full = 0. Memory contents are not cleared. Reset asserted mid-operation discards all data immediately.
- Request acceptance: a write is accepted when Wren=1 and not Full. A read is accepted when Rden=1 and not Empty. Exceptions for simultaneous requests are listed below.
- Rejected write: Overflow=1 for one cycle; storage unchanged. Rejected read: Underflow=1 for one cycle; Dataout holds; Rvalid=0.
- Read latency: 1 cycle. Dataout and Rvalid are registered on the edge that accepts the read. Dataout holds its value when no read is accepted.
- Full, Empty and Count are registered and reflect the state after the edge.
- Queue mode (MODE=1):
  - Write stores to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
  - Read returns mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - Pointers wrap naturally at DEPTH.
  - Simultaneous Wren and Rden, non-empty (including full): both accepted; Count unchanged.
  - Simultaneous Wren and Rden, empty: write accepted, Underflow pulses, Count becomes 1.
- Stack mode (MODE=0):
  - Single pointer sp equals Count.
  - Push stores to mem[sp]; sp+1.
  - Pop returns mem[sp-1]; sp-1.
  - Simultaneous Wren and Rden, non-empty (including full): Dataout = current top, then top is replaced by Datain; sp unchanged; no Overflow.
  - Simultaneous Wren and Rden, empty: push accepted, Underflow pulses.
- Count arithmetic: ADDR_WIDTH+1 bits; +1 on accepted write only, -1 on accepted read only; never exceeds DEPTH.
- Memory: synchronous write; registered read address path.

Optional Feature:
XIFO_ALMOST_EN.
- Defined: adds outputs Almost_full = (Count >= AF_LEVEL) and Almost_empty = (Count <= AE_LEVEL). Both are registered and reset to 0 and 1 respectively.
- Undefined: these ports and the AF_LEVEL/AE_LEVEL logic are absent.

Decomposition:
- Package xifo_pkg: MODE_STACK = 0 and MODE_QUEUE = 1 constants, min/max SIZE and ADDR_WIDTH limits, clog helper function.
- Sub-module xifo_ram: simple dual-port memory (one write port, one read port, registered output), parametrised by SIZE and ADDR_WIDTH.
- Pointer, count and flag logic stays in xifo_buffer.

Test Plan:
All scenarios use SIZE=16, ADDR_WIDTH=3 (DEPTH=8).
- Queue: write 0x0001..0x0008 -> Full=1, Count=8. 9th write -> Overflow pulse. Eight reads return 0x0001..0x0008 in order, each Rvalid one cycle after Rden. Then Empty=1.
- Stack: push 0xA1, 0xA2, 0xA3, then pop three times -> 0xA3, 0xA2, 0xA1. 4th pop -> Underflow pulse, Dataout stays 0xA1.
- Queue wrap: write 5, read 5, write 8 -> Full=1. Read all 8 -> correct order across pointer wrap.
- Simultaneous: queue full with Wren=Rden=1 -> oldest returned, Count stays 8. Stack with top 0x55, Wren=Rden=1, Datain=0x66 -> Dataout=0x55, next pop returns 0x66. Empty with both -> Underflow pulse, Count=1.
- Reset mid-operation: Count=5, assert Rst between clock edges -> Count=0, Empty=1, Dataout=0 immediately. Read after release -> Underflow.
- XIFO_ALMOST_EN (AF_LEVEL=6, AE_LEVEL=1): Count 0→7 -> Almost_empty high at Count 0–1, Almost_full high from Count 6.
